// File: rtl/rock_regelaar.sv
// Cradle rocking regulator: adapts rocking amplitude and frequency
// from cry-volume and heart-rate samples once per evaluation round.
module rock_regelaar #(
  parameter int W          = 8,
  parameter int LVL_W      = 3,
  parameter int DIV        = 1000,
  parameter int TIMEOUT    = 16,
  parameter int HOLD_TICKS = 4,
  parameter int HYST       = 2,
  parameter int QUIET      = 10,
  parameter int HART_HI    = 150
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     huil_vol,
  input  logic             huil_valid,
  input  logic [W-1:0]     hartslag,
  input  logic             hart_valid,
  output logic [LVL_W-1:0] amp,
  output logic [LVL_W-1:0] freq,
  output logic [2:0]       state,
  output logic             tick,
  output logic             restart_pulse
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_EVAL    = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_RESTART = 3'd4;

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int CW = 16;

  localparam logic [PW-1:0]    PMAX  = PW'(DIV - 1);
  localparam logic [PW-1:0]    PONE  = PW'(1);
  localparam logic [CW-1:0]    TO_M1 = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]    HO_M1 = CW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0]    CONE  = CW'(1);
  localparam logic [LVL_W-1:0] LMAX  = '1;
  localparam logic [LVL_W-1:0] LONE  = LVL_W'(1);
  localparam logic [W:0]       HYS_X = (W+1)'(HYST);
  localparam logic [W:0]       QUI_X = (W+1)'(QUIET);
  localparam logic [W:0]       HHI_X = (W+1)'(HART_HI);

  logic [PW-1:0]    pcnt;
  logic [CW-1:0]    wcnt;
  logic [CW-1:0]    hcnt;
  logic             hf;
  logic             bf;
  logic [W-1:0]     huil_cur;
  logic [W-1:0]     hart_cur;
  logic [W-1:0]     huil_prev;
  logic [LVL_W-1:0] amp_n;
  logic [LVL_W-1:0] freq_n;
  logic [W:0]       cur_x;
  logic [W:0]       prev_x;
  logic [W:0]       hart_x;
  logic             both;

  always_comb begin
    tick          = (pcnt == PMAX);
    restart_pulse = (state == S_RESTART);
    // A strobe in this cycle counts as already flagged.
    both          = (hf | huil_valid) & (bf | hart_valid);
  end

  always_comb begin
    cur_x  = {1'b0, huil_cur};
    prev_x = {1'b0, huil_prev};
    hart_x = {1'b0, hart_cur};
    amp_n  = amp;
    freq_n = freq;
    if (cur_x <= QUI_X) begin
      if (amp != '0) amp_n = amp - LONE;
    end else if (cur_x > prev_x + HYS_X) begin
      if (amp != LMAX) amp_n = amp + LONE;
      else if (freq != LMAX) freq_n = freq + LONE;
    end else if (cur_x + HYS_X < prev_x) begin
      amp_n  = amp;
    end else if (hart_x > HHI_X && freq != '0) begin
      freq_n = freq - LONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pcnt      <= '0;
      wcnt      <= '0;
      hcnt      <= '0;
      hf        <= 1'b0;
      bf        <= 1'b0;
      huil_cur  <= '0;
      hart_cur  <= '0;
      huil_prev <= '0;
      amp       <= '0;
      freq      <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + PONE;
      if (huil_valid) huil_cur <= huil_vol;
      if (hart_valid) hart_cur <= hartslag;

      if (state == S_RESTART) hf <= 1'b0;
      else if (huil_valid)    hf <= 1'b1;
      else if (state == S_EVAL) hf <= 1'b0;

      if (state == S_RESTART) bf <= 1'b0;
      else if (hart_valid)    bf <= 1'b1;
      else if (state == S_EVAL) bf <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (both) state <= S_EVAL;
        end
        S_WAIT: begin
          if (both) begin
            state <= S_EVAL;
          end else if (tick) begin
            if (wcnt == TO_M1) state <= S_RESTART;
            else wcnt <= wcnt + CONE;
          end
        end
        S_EVAL: begin
          amp       <= amp_n;
          freq      <= freq_n;
          huil_prev <= huil_cur;
          hcnt      <= '0;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (tick) begin
            if (hcnt == HO_M1) begin
              state <= S_WAIT;
              wcnt  <= '0;
            end else begin
              hcnt <= hcnt + CONE;
            end
          end
        end
        S_RESTART: begin
          amp       <= '0;
          freq      <= '0;
          huil_prev <= '0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rock_regelaar.sv
// Bench for rock_regelaar: table of evaluation rounds, corner sequences
// and random traffic, all checked against a behavioural model.
module tb_rock_regelaar;

  localparam int W = 8, LW = 3, DIV = 4, TMO = 3, HOLD = 2;
  localparam int HYST = 2, QUIET = 10, HHI = 150, LMAX = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  huil_vol = '0;
  logic          huil_valid = 1'b0;
  logic [W-1:0]  hartslag = '0;
  logic          hart_valid = 1'b0;
  logic [LW-1:0] amp;
  logic [LW-1:0] freq;
  logic [2:0]    st;
  logic          tick;
  logic          restart_pulse;

  rock_regelaar #(
    .W(W), .LVL_W(LW), .DIV(DIV), .TIMEOUT(TMO), .HOLD_TICKS(HOLD),
    .HYST(HYST), .QUIET(QUIET), .HART_HI(HHI)
  ) dut (
    .clk(clk), .reset(reset),
    .huil_vol(huil_vol), .huil_valid(huil_valid),
    .hartslag(hartslag), .hart_valid(hart_valid),
    .amp(amp), .freq(freq), .state(st),
    .tick(tick), .restart_pulse(restart_pulse)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 0;

  // model state: spec state codes, plain integers
  int m_state, m_p, m_w, m_h, m_cur, m_hcur, m_prev, m_amp, m_freq;
  bit m_hf, m_bf;

  typedef struct {
    int huil;
    int hart;
    int amp;
    int freq;
  } vec_t;
  vec_t tbl[27];

  task automatic expect_eq(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    int ea, ef, es, et, er;
    ea = m_amp; ef = m_freq; es = m_state;
    et = (m_p == DIV - 1) ? 1 : 0;
    er = (m_state == 4) ? 1 : 0;
    nvec++;
    if (amp !== LW'(ea) || freq !== LW'(ef) || st !== 3'(es) ||
        tick !== 1'(et) || restart_pulse !== 1'(er)) begin
      nerr++;
      $display("FAIL cycle t=%0t amp/freq/state/tick/rp got %0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d",
               $time, amp, freq, st, tick, restart_pulse, ea, ef, es, et, er);
    end
  endtask

  task automatic model_step(input bit hv, input int hvol,
                            input bit bv, input int bvol, input bit rst);
    bit tk, have_h, have_b;
    int n_state, n_w, n_h, n_amp, n_freq, n_prev;
    bit n_hf, n_bf;
    if (rst) begin
      m_state = 0; m_p = 0; m_w = 0; m_h = 0; m_cur = 0; m_hcur = 0;
      m_prev = 0; m_amp = 0; m_freq = 0; m_hf = 0; m_bf = 0;
      return;
    end
    tk = (m_p == DIV - 1);
    have_h = m_hf || hv;
    have_b = m_bf || bv;
    n_state = m_state; n_w = m_w; n_h = m_h;
    n_amp = m_amp; n_freq = m_freq; n_prev = m_prev;
    n_hf = m_hf; n_bf = m_bf;
    if (m_state == 4) begin n_hf = 0; n_bf = 0; end
    else begin
      if (hv) n_hf = 1; else if (m_state == 2) n_hf = 0;
      if (bv) n_bf = 1; else if (m_state == 2) n_bf = 0;
    end
    case (m_state)
      0: if (have_h && have_b) n_state = 2;
      1: begin
        if (have_h && have_b) n_state = 2;
        else if (tk) begin
          n_w = m_w + 1;
          if (n_w >= TMO) n_state = 4;
        end
      end
      2: begin
        if (m_cur <= QUIET) n_amp = (m_amp > 0) ? m_amp - 1 : 0;
        else if (m_cur > m_prev + HYST) begin
          if (m_amp < LMAX) n_amp = m_amp + 1;
          else n_freq = (m_freq < LMAX) ? m_freq + 1 : LMAX;
        end else if (m_cur + HYST < m_prev) n_amp = m_amp;
        else if (m_hcur > HHI && m_freq > 0) n_freq = m_freq - 1;
        n_prev = m_cur; n_h = 0; n_state = 3;
      end
      3: if (tk) begin
        n_h = m_h + 1;
        if (n_h >= HOLD) begin n_state = 1; n_w = 0; end
      end
      default: begin
        n_amp = 0; n_freq = 0; n_prev = 0; n_state = 0;
      end
    endcase
    if (hv) m_cur = hvol;
    if (bv) m_hcur = bvol;
    m_p = tk ? 0 : m_p + 1;
    m_state = n_state; m_w = n_w; m_h = n_h; m_amp = n_amp;
    m_freq = n_freq; m_prev = n_prev; m_hf = n_hf; m_bf = n_bf;
  endtask

  // Called at a falling edge: drive, check, advance one clock.
  task automatic cyc(input bit hv, input int hvol,
                     input bit bv, input int bvol, input bit rst);
    huil_valid = hv; huil_vol = hvol[7:0];
    hart_valid = bv; hartslag = bvol[7:0];
    reset = rst;
    if (chk_en) check_cycle();
    model_step(hv, hvol, bv, bvol, rst);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!(m_state == 0 || m_state == 1) && n < 60) begin
      idle();
      n++;
    end
    expect_eq("wait_ready_bound", (n < 60) ? 1 : 0, 1);
  endtask

  task automatic round(input int hv, input int bv);
    wait_ready();
    cyc(1, hv, 1, bv, 0);
    idle();
  endtask

  initial begin
    int ticks, rps, seen, v;
    tbl[0]  = '{50, 100, 1, 0};  tbl[1]  = '{60, 100, 2, 0};
    tbl[2]  = '{70, 100, 3, 0};  tbl[3]  = '{80, 100, 4, 0};
    tbl[4]  = '{90, 100, 5, 0};  tbl[5]  = '{100, 100, 6, 0};
    tbl[6]  = '{110, 100, 7, 0}; tbl[7]  = '{120, 100, 7, 1};
    tbl[8]  = '{130, 100, 7, 2}; tbl[9]  = '{140, 100, 7, 3};
    tbl[10] = '{141, 160, 7, 2}; tbl[11] = '{142, 100, 7, 2};
    tbl[12] = '{130, 160, 7, 2}; tbl[13] = '{8, 160, 6, 2};
    tbl[14] = '{150, 100, 7, 2}; tbl[15] = '{200, 100, 7, 3};
    tbl[16] = '{210, 100, 7, 4}; tbl[17] = '{220, 100, 7, 5};
    tbl[18] = '{230, 100, 7, 6}; tbl[19] = '{240, 100, 7, 7};
    tbl[20] = '{250, 100, 7, 7}; tbl[21] = '{255, 151, 7, 7};
    tbl[22] = '{255, 151, 7, 6}; tbl[23] = '{253, 150, 7, 6};
    tbl[24] = '{252, 200, 7, 5}; tbl[25] = '{10, 200, 6, 5};
    tbl[26] = '{11, 200, 6, 4};

    @(negedge clk);
    cyc(0, 0, 0, 0, 1);
    chk_en = 1;

    ticks = 0; rps = 0;
    for (int i = 0; i < 20; i++) begin
      if (tick) ticks++;
      if (restart_pulse) rps++;
      idle();
    end
    expect_eq("idle_ticks", ticks, 5);
    expect_eq("idle_no_restart", rps, 0);
    expect_eq("idle_state", st, 0);

    for (int i = 0; i < 27; i++) begin
      round(tbl[i].huil, tbl[i].hart);
      expect_eq($sformatf("tbl%0d_amp", i), amp, tbl[i].amp);
      expect_eq($sformatf("tbl%0d_freq", i), freq, tbl[i].freq);
    end

    // strobe during EVAL keeps its flag for the next round
    wait_ready();
    cyc(1, 60, 1, 100, 0);
    expect_eq("eval_entered", st, 2);
    cyc(1, 77, 0, 0, 0);
    wait_ready();
    expect_eq("wait_reached", st, 1);
    cyc(0, 0, 1, 100, 0);
    expect_eq("retained_flag_eval", st, 2);
    idle();

    // reset in EVAL wins over level update
    wait_ready();
    cyc(1, 200, 1, 100, 0);
    expect_eq("eval_before_reset", st, 2);
    cyc(0, 0, 0, 0, 1);
    expect_eq("rst_eval_state", st, 0);
    expect_eq("rst_eval_amp", amp, 0);
    expect_eq("rst_eval_freq", freq, 0);
    expect_eq("rst_eval_rp", restart_pulse, 0);

    // timeout in WAIT with only cry samples
    round(90, 100);
    round(120, 100);
    wait_ready();
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (restart_pulse) seen = 1;
      else cyc(1, 130, 0, 0, 0);
    end
    expect_eq("timeout_restart", seen, 1);
    expect_eq("restart_state", st, 4);
    idle();
    expect_eq("post_restart_state", st, 0);
    expect_eq("post_restart_amp", amp, 0);
    expect_eq("post_restart_freq", freq, 0);

    for (int i = 0; i < 4000; i++) begin
      bit hv, bv, rs;
      hv = ($urandom_range(0, 5) == 0);
      bv = ($urandom_range(0, 5) == 0);
      rs = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 1) == 1) begin
        v = m_prev + int'($urandom_range(0, 6)) - 3;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
      end else begin
        v = int'($urandom_range(0, 255));
      end
      cyc(hv, v, bv, int'($urandom_range(100, 200)), rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
